mult_arbiter: RTL and testbench
===============================

Name: mult_arbiter

Overview:
Shares one 16x16 signed multiplier (req/ack/result_rdy protocol, per-argument parity) between N_REQ requesters. Round-robin arbitration, one operation in flight at a time. Drives the multiplier argument/req inputs and returns result, result parity, parity-error and timeout status to the granted requester. Sits between client blocks and the multiplier datapath.

Parameters:
N_REQ, 4, number of requesters (2..8)
TIMEOUT_CYC, 64, max cycles from m_req assertion to m_result_rdy before abort (>=4)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
cli_req  in  N_REQ  per-requester operation request (level)
cli_arg_a  in  N_REQ*16  signed arg A, requester i at [16i+15:16i]
cli_arg_a_parity  in  N_REQ  parity bit for arg A
cli_arg_b  in  N_REQ*16  signed arg B, same packing
cli_arg_b_parity  in  N_REQ  parity bit for arg B
cli_gnt  out  N_REQ  one-cycle pulse: requester's args captured
cli_done  out  N_REQ  one-cycle pulse: response valid for that requester
rsp_result  out  32  signed product (0 on timeout)
rsp_result_parity  out  1  parity from multiplier
rsp_parity_error  out  1  multiplier arg_parity_error
rsp_timeout  out  1  operation aborted by watchdog
m_arg_a  out  16  multiplier arg A
m_arg_a_parity  out  1
m_arg_b  out  16  multiplier arg B
m_arg_b_parity  out  1
m_req  out  1  multiplier request
m_ack  in  1  multiplier accepted arguments
m_result  in  32  multiplier product
m_result_parity  in  1
m_result_rdy  in  1  multiplier result valid
m_arg_parity_error  in  1

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, RR pointer -> requester 0 highest priority, timeout counter 0. Mid-operation reset drops m_req immediately; no cli_done for the aborted op.
- FSM states IDLE, ISSUE, WAIT_RDY, RESP; all outputs registered.
- IDLE: if any cli_req, choose first set bit at/after RR pointer (wrap). On that edge: latch its args/parities into m_*, m_req<=1, cli_gnt[i]<=1 (one cycle), owner<=i, counter<=0, -> ISSUE. m_result_rdy/m_ack ignored in IDLE.
- ISSUE: m_req held, m_* stable. m_ack=1: m_req<=0, -> WAIT_RDY; if m_result_rdy also 1 same cycle, capture result and -> RESP directly.
- WAIT_RDY: m_result_rdy=1: capture m_result, m_result_parity, m_arg_parity_error into rsp_*, rsp_timeout<=0, -> RESP.
- Timeout: counter increments each cycle in ISSUE/WAIT_RDY; at counter==TIMEOUT_CYC-1 without completion: m_req<=0, rsp_result<=0, rsp_parity_error<=0, rsp_timeout<=1, -> RESP. Completion wins if same cycle.
- RESP: cli_done[owner]=1 for exactly this cycle; RR pointer<=owner+1 mod N_REQ; -> IDLE. rsp_* hold until next capture.
- Latency: cli_req sampled in IDLE -> gnt/m_req next edge; m_result_rdy sampled -> cli_done next edge. Back-to-back: one IDLE cycle between cli_done and next cli_gnt.
- Requesters keep args stable while cli_req high until cli_gnt; a cli_req still high after cli_done re-competes normally.
- Parity passed through unchecked; error reporting is the multiplier's.

Decomposition:
- Package mult_arb_pkg: ARG_W=16, RES_W=32, state enum typedef (IDLE/ISSUE/WAIT_RDY/RESP), response struct (result, parity, parity_error, timeout).
- Sub-module mult_rr_pick: combinational rotating-priority picker (req vector, pointer -> one-hot grant, index, any).

Test Plan:
- req0 only, a=3, b=-4, correct parities; model ack at +2, rdy at +5 -> cli_gnt[0] 1 cycle after req, m_arg_a=3, m_arg_b=-4; cli_done[0] with rsp_result=-12, rsp_parity_error=0, rsp_timeout=0.
- All 4 cli_req high from reset, held -> grant order 0,1,2,3,0; then only req0 and req2 high -> 1 is skipped, order 2,0,2.
- req1 a=7 with wrong arg_a parity; model returns arg_parity_error=1, result 0 -> cli_done[1], rsp_parity_error=1.
- Model never acks, TIMEOUT_CYC=16 -> m_req low after 16 cycles, cli_done[0], rsp_timeout=1, rsp_result=0; next request served normally.
- Model asserts m_ack and m_result_rdy same cycle, result 100 -> no WAIT_RDY, cli_done next edge with rsp_result=100.
- rst_n low during WAIT_RDY -> m_req, cli_*, rsp_* 0 immediately; late m_result_rdy after release ignored, no cli_done.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// Shared widths, FSM state encoding and response record for the multiplier arbiter.
// Pure declarations: no logic, no latency, no backpressure.
package mult_arb_pkg;

  localparam int ARG_W = 16;
  localparam int RES_W = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RDY = 2'd2,
    RESP     = 2'd3
  } state_t;

  typedef struct packed {
    logic [RES_W-1:0] result;
    logic             parity;
    logic             parity_error;
    logic             timeout;
  } rsp_t;

endpackage

// File: rtl/mult_rr_pick.sv
// Rotating-priority picker: first asserted request at or after ptr_i, wrapping.
// Purely combinational (zero latency); no backpressure of its own.
module mult_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  always_comb begin
    int j;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(ptr_i) + k) % N_REQ;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        idx_o    = IDX_W'(j);
        gnt_o[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin share of one req/ack multiplier among N_REQ clients, one op in flight, watchdog abort.
// Grant one edge after cli_req seen in IDLE; cli_done one edge after m_result_rdy; clients wait on cli_req until granted.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       cli_req,
  input  logic [N_REQ*ARG_W-1:0] cli_arg_a,
  input  logic [N_REQ-1:0]       cli_arg_a_parity,
  input  logic [N_REQ*ARG_W-1:0] cli_arg_b,
  input  logic [N_REQ-1:0]       cli_arg_b_parity,
  output logic [N_REQ-1:0]       cli_gnt,
  output logic [N_REQ-1:0]       cli_done,
  output logic [RES_W-1:0]       rsp_result,
  output logic                   rsp_result_parity,
  output logic                   rsp_parity_error,
  output logic                   rsp_timeout,
  output logic [ARG_W-1:0]       m_arg_a,
  output logic                   m_arg_a_parity,
  output logic [ARG_W-1:0]       m_arg_b,
  output logic                   m_arg_b_parity,
  output logic                   m_req,
  input  logic                   m_ack,
  input  logic [RES_W-1:0]       m_result,
  input  logic                   m_result_parity,
  input  logic                   m_result_rdy,
  input  logic                   m_arg_parity_error
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ARG_W-1:0]   m_arg_a_q, m_arg_a_d, m_arg_b_q, m_arg_b_d;
  logic               m_arg_a_par_q, m_arg_a_par_d, m_arg_b_par_q, m_arg_b_par_d;
  logic               m_req_q, m_req_d;
  logic [N_REQ-1:0]   cli_gnt_q, cli_gnt_d, cli_done_q, cli_done_d;
  rsp_t               rsp_q, rsp_d;

  logic [N_REQ-1:0]   pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               expired;
  rsp_t               rsp_cap;

  mult_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req_i (cli_req),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign expired = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign rsp_cap = '{result: m_result, parity: m_result_parity,
                     parity_error: m_arg_parity_error, timeout: 1'b0};

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    cnt_d         = cnt_q;
    m_arg_a_d     = m_arg_a_q;
    m_arg_b_d     = m_arg_b_q;
    m_arg_a_par_d = m_arg_a_par_q;
    m_arg_b_par_d = m_arg_b_par_q;
    m_req_d       = m_req_q;
    cli_gnt_d     = '0;
    cli_done_d    = '0;
    rsp_d         = rsp_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          m_arg_a_d     = cli_arg_a[int'(pick_idx)*ARG_W +: ARG_W];
          m_arg_b_d     = cli_arg_b[int'(pick_idx)*ARG_W +: ARG_W];
          m_arg_a_par_d = cli_arg_a_parity[pick_idx];
          m_arg_b_par_d = cli_arg_b_parity[pick_idx];
          m_req_d       = 1'b1;
          cli_gnt_d     = pick_gnt;
          owner_d       = pick_idx;
          cnt_d         = '0;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d = cnt_q + 1'b1;
        // A result arriving with the ack is a completion and beats the watchdog.
        if (m_ack && m_result_rdy) begin
          m_req_d               = 1'b0;
          rsp_d                 = rsp_cap;
          cli_done_d[owner_q]   = 1'b1;
          state_d               = RESP;
        end else if (expired) begin
          m_req_d             = 1'b0;
          rsp_d               = '{result: '0, parity: 1'b0, parity_error: 1'b0, timeout: 1'b1};
          cli_done_d[owner_q] = 1'b1;
          state_d             = RESP;
        end else if (m_ack) begin
          m_req_d = 1'b0;
          state_d = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        cnt_d = cnt_q + 1'b1;
        if (m_result_rdy) begin
          rsp_d               = rsp_cap;
          cli_done_d[owner_q] = 1'b1;
          state_d             = RESP;
        end else if (expired) begin
          rsp_d               = '{result: '0, parity: 1'b0, parity_error: 1'b0, timeout: 1'b1};
          cli_done_d[owner_q] = 1'b1;
          state_d             = RESP;
        end
      end
      RESP: begin
        ptr_d   = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      owner_q       <= '0;
      cnt_q         <= '0;
      m_arg_a_q     <= '0;
      m_arg_b_q     <= '0;
      m_arg_a_par_q <= 1'b0;
      m_arg_b_par_q <= 1'b0;
      m_req_q       <= 1'b0;
      cli_gnt_q     <= '0;
      cli_done_q    <= '0;
      rsp_q         <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      cnt_q         <= cnt_d;
      m_arg_a_q     <= m_arg_a_d;
      m_arg_b_q     <= m_arg_b_d;
      m_arg_a_par_q <= m_arg_a_par_d;
      m_arg_b_par_q <= m_arg_b_par_d;
      m_req_q       <= m_req_d;
      cli_gnt_q     <= cli_gnt_d;
      cli_done_q    <= cli_done_d;
      rsp_q         <= rsp_d;
    end
  end

  assign cli_gnt           = cli_gnt_q;
  assign cli_done          = cli_done_q;
  assign rsp_result        = rsp_q.result;
  assign rsp_result_parity = rsp_q.parity;
  assign rsp_parity_error  = rsp_q.parity_error;
  assign rsp_timeout       = rsp_q.timeout;
  assign m_arg_a           = m_arg_a_q;
  assign m_arg_a_parity    = m_arg_a_par_q;
  assign m_arg_b           = m_arg_b_q;
  assign m_arg_b_parity    = m_arg_b_par_q;
  assign m_req             = m_req_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: behavioural multiplier model plus a response scoreboard.
module tb_mult_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    cli_req = '0;
  logic [N*16-1:0] cli_arg_a = '0;
  logic [N-1:0]    cli_arg_a_parity = '0;
  logic [N*16-1:0] cli_arg_b = '0;
  logic [N-1:0]    cli_arg_b_parity = '0;
  logic [N-1:0]    cli_gnt, cli_done;
  logic [31:0]     rsp_result;
  logic            rsp_result_parity, rsp_parity_error, rsp_timeout;
  logic [15:0]     m_arg_a, m_arg_b;
  logic            m_arg_a_parity, m_arg_b_parity, m_req;
  logic            m_ack, m_result_parity, m_result_rdy, m_arg_parity_error;
  logic [31:0]     m_result;

  always #5 clk = ~clk;

  mult_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cli_req(cli_req), .cli_arg_a(cli_arg_a), .cli_arg_a_parity(cli_arg_a_parity),
    .cli_arg_b(cli_arg_b), .cli_arg_b_parity(cli_arg_b_parity),
    .cli_gnt(cli_gnt), .cli_done(cli_done),
    .rsp_result(rsp_result), .rsp_result_parity(rsp_result_parity),
    .rsp_parity_error(rsp_parity_error), .rsp_timeout(rsp_timeout),
    .m_arg_a(m_arg_a), .m_arg_a_parity(m_arg_a_parity),
    .m_arg_b(m_arg_b), .m_arg_b_parity(m_arg_b_parity),
    .m_req(m_req), .m_ack(m_ack), .m_result(m_result),
    .m_result_parity(m_result_parity), .m_result_rdy(m_result_rdy),
    .m_arg_parity_error(m_arg_parity_error)
  );

  typedef struct {
    int          idx;
    logic [31:0] res;
    logic        perr;
    logic        tmo;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   ack_dly = 2;   // 0 = never
  int   rdy_dly = 5;   // 0 = never

  function automatic exp_t mk(int idx, int res, bit perr, bit tmo);
    exp_t e;
    e.idx = idx; e.res = res; e.perr = perr; e.tmo = tmo;
    return e;
  endfunction

  task automatic set_args(int i, logic [15:0] a, logic [15:0] b, bit bad_a);
    cli_arg_a[i*16 +: 16] = a;
    cli_arg_b[i*16 +: 16] = b;
    cli_arg_a_parity[i]   = (^a) ^ bad_a;
    cli_arg_b_parity[i]   = ^b;
  endtask

  task automatic wait_gnt(output int n);
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (cli_gnt != 0) begin n = k; break; end
    end
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (sb.size() == 0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  // Multiplier model: ack and rdy pulse a fixed number of cycles after m_req rises.
  initial begin
    int cyc;
    bit in_op, acked, perr;
    logic signed [31:0] pa, pb;
    m_ack = 0; m_result_rdy = 0; m_result = 0; m_result_parity = 0; m_arg_parity_error = 0;
    cyc = 0; in_op = 0; acked = 0;
    forever begin
      @(negedge clk);
      m_ack = 0; m_result_rdy = 0;
      if (!in_op) begin
        if (m_req === 1'b1) begin in_op = 1; acked = 0; cyc = 1; end
      end else begin
        cyc++;
        if (!acked && m_req !== 1'b1) in_op = 0;
      end
      if (in_op) begin
        if (cyc == ack_dly) begin m_ack = 1; acked = 1; end
        if (cyc == rdy_dly) begin
          perr = ((^m_arg_a) !== m_arg_a_parity) || ((^m_arg_b) !== m_arg_b_parity);
          pa = $signed(m_arg_a);
          pb = $signed(m_arg_b);
          m_result = perr ? 32'd0 : pa * pb;
          m_result_parity = ^m_result;
          m_arg_parity_error = perr;
          m_result_rdy = 1;
          in_op = 0;
        end
      end
    end
  end

  // Scoreboard consumer: every cli_done pulse must match the oldest expectation.
  initial begin
    forever begin
      exp_t e;
      logic [N-1:0] one;
      @(negedge clk);
      if (cli_done != 0) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL done_unexpected cli_done=%b required none", cli_done);
        end else begin
          e = sb.pop_front();
          one = 4'b0001;
          one = one << e.idx;
          if (cli_done !== one || rsp_result !== e.res || rsp_parity_error !== e.perr ||
              rsp_timeout !== e.tmo || rsp_result_parity !== ^e.res) begin
            failures++;
            $display("FAIL rsp done=%b res=%0d perr=%b tmo=%b par=%b required done=%b res=%0d perr=%b tmo=%b par=%b",
                     cli_done, $signed(rsp_result), rsp_parity_error, rsp_timeout, rsp_result_parity,
                     one, $signed(e.res), e.perr, e.tmo, ^e.res);
          end
        end
      end
    end
  end

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({m_req, cli_gnt, cli_done, rsp_result, rsp_timeout, rsp_parity_error, m_arg_a, m_arg_b} !== '0) begin
      failures++;
      $display("FAIL reset_outputs m_req=%b gnt=%b done=%b res=%h required all zero",
               m_req, cli_gnt, cli_done, rsp_result);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (m_req !== 1'b0 || cli_gnt !== '0) begin
      failures++;
      $display("FAIL idle_no_req m_req=%b gnt=%b required 0", m_req, cli_gnt);
    end
  endtask

  task automatic test_single;
    int n, lat;
    bit ok;
    ack_dly = 2; rdy_dly = 5;
    set_args(0, 16'd3, 16'hFFFC, 1'b0);
    sb.push_back(mk(0, -12, 1'b0, 1'b0));
    cli_req = 4'b0001;
    wait_gnt(n);
    cli_req = '0;
    checks++;
    if (n != 1) begin failures++; $display("FAIL single_gnt_latency got=%0d required 1", n); end
    checks++;
    if (cli_gnt !== 4'b0001) begin failures++; $display("FAIL single_gnt got=%b required 0001", cli_gnt); end
    checks++;
    if (m_req !== 1'b1 || m_arg_a !== 16'd3 || m_arg_b !== 16'hFFFC) begin
      failures++;
      $display("FAIL single_args m_req=%b a=%h b=%h required 1 0003 fffc", m_req, m_arg_a, m_arg_b);
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        checks++;
        if (cli_gnt !== '0) begin failures++; $display("FAIL gnt_pulse got=%b required 0000", cli_gnt); end
      end
    end while (cli_done == 0 && lat < 40);
    checks++;
    if (lat != 5) begin failures++; $display("FAIL single_done_latency got=%0d required 5", lat); end
    wait_drain(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL single_drain pending=%0d required 0", sb.size()); end
  endtask

  task automatic test_rr;
    int exp_ord[8] = '{0, 1, 2, 3, 0, 2, 0, 2};
    int got[$];
    int g;
    bit ok;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ack_dly = 1; rdy_dly = 2;
    for (int i = 0; i < N; i++) set_args(i, 16'(i + 1), 16'd10, 1'b0);
    for (int k = 0; k < 8; k++) sb.push_back(mk(exp_ord[k], (exp_ord[k] + 1) * 10, 1'b0, 1'b0));
    cli_req = 4'b1111;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (cli_gnt != 0) begin
        g = 0;
        for (int i = 0; i < N; i++) if (cli_gnt[i]) g = i;
        got.push_back(g);
        if (got.size() == 5) cli_req = 4'b0101;
        if (got.size() == 8) begin cli_req = '0; break; end
      end
    end
    checks++;
    if (got.size() != 8) begin failures++; $display("FAIL rr_count got=%0d required 8", got.size()); end
    for (int k = 0; k < got.size() && k < 8; k++) begin
      checks++;
      if (got[k] != exp_ord[k]) begin
        failures++;
        $display("FAIL rr_order[%0d] got=%0d required %0d", k, got[k], exp_ord[k]);
      end
    end
    wait_drain(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rr_drain pending=%0d required 0", sb.size()); end
  endtask

  task automatic test_parity_err;
    int n;
    bit ok;
    ack_dly = 2; rdy_dly = 5;
    set_args(1, 16'd7, 16'd2, 1'b1);
    sb.push_back(mk(1, 0, 1'b1, 1'b0));
    cli_req = 4'b0010;
    wait_gnt(n);
    cli_req = '0;
    checks++;
    if (m_arg_a_parity !== 1'b0) begin
      failures++;
      $display("FAIL parity_passthru got=%b required 0", m_arg_a_parity);
    end
    wait_drain(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL parity_drain pending=%0d required 0", sb.size()); end
  endtask

  task automatic test_timeout;
    int n, cnt;
    bit ok;
    ack_dly = 0; rdy_dly = 0;
    set_args(0, 16'd5, 16'd5, 1'b0);
    sb.push_back(mk(0, 0, 1'b0, 1'b1));
    cli_req = 4'b0001;
    wait_gnt(n);
    cli_req = '0;
    cnt = 0;
    while (m_req === 1'b1 && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    checks++;
    if (cnt != TO) begin failures++; $display("FAIL timeout_mreq_cycles got=%0d required %0d", cnt, TO); end
    wait_drain(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL timeout_drain pending=%0d required 0", sb.size()); end
    ack_dly = 2; rdy_dly = 4;
    set_args(3, 16'hFFFE, 16'd9, 1'b0);
    sb.push_back(mk(3, -18, 1'b0, 1'b0));
    cli_req = 4'b1000;
    wait_gnt(n);
    cli_req = '0;
    wait_drain(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL after_timeout_drain pending=%0d required 0", sb.size()); end
  endtask

  task automatic test_same_cycle;
    int n, lat;
    ack_dly = 3; rdy_dly = 3;
    set_args(2, 16'd10, 16'd10, 1'b0);
    sb.push_back(mk(2, 100, 1'b0, 1'b0));
    cli_req = 4'b0100;
    wait_gnt(n);
    cli_req = '0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (cli_done == 0 && lat < 40);
    checks++;
    if (lat != 3) begin failures++; $display("FAIL same_cycle_latency got=%0d required 3", lat); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int n;
    bit seen;
    ack_dly = 1; rdy_dly = 12;
    set_args(0, 16'd4, 16'd4, 1'b0);
    cli_req = 4'b0001;
    wait_gnt(n);
    cli_req = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({m_req, cli_gnt, cli_done, rsp_result, rsp_result_parity, rsp_parity_error, rsp_timeout,
         m_arg_a, m_arg_b} !== '0) begin
      failures++;
      $display("FAIL reset_mid m_req=%b gnt=%b done=%b res=%h a=%h required all zero",
               m_req, cli_gnt, cli_done, rsp_result, m_arg_a);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (cli_done != 0 || m_req !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin failures++; $display("FAIL late_rdy_ignored activity=1 required 0"); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_parity_err();
    test_timeout();
    test_same_cycle();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL final_scoreboard pending=%0d required 0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
